rr_arbiter_16: RTL and testbench

Sixteen-requester round-robin arbiter granting exclusive access to one shared resource, such as a TLB port, a write-back path or a bus master interface. Requests are collected as a 16-bit vector. The arbiter issues a registered one-hot grant together with its 4-bit encoded index. It then holds that grant through an accept/done handshake with the resource. Priority rotates so the most recently accepted requester has lowest priority in the next arbitration.

---
 rtl/rr_arbiter_16.sv | 163 ++++++++++++++++
 tb/tb_rr_arbiter_16.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_16.sv
// Sixteen-requester round-robin arbiter with a GRANT/BUSY handshake to one shared resource.
// Optional forced release after TIMEOUT busy cycles, enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_16 #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] req,
   input  logic        out_ready,
   input  logic        done,
   output logic [15:0] gnt,
   output logic [3:0]  gnt_idx,
   output logic        gnt_valid,
   output logic        busy,
   output logic        timeout
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_BUSY  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] gnt_q, gnt_d;
   logic [3:0]  gnt_idx_q, gnt_idx_d;
   logic        gnt_valid_q, gnt_valid_d;
   logic        busy_q, busy_d;
   logic [3:0]  ptr_q, ptr_d;

   logic [15:0] req_rot;
   logic [3:0]  first_off;
   logic [3:0]  sel_idx;
   logic [15:0] sel_oh;

`ifdef ARB_TIMEOUT_EN
   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);
   logic [15:0] cnt_q, cnt_d;
   logic        timeout_q, timeout_d;
`else
   logic unused_timeout_param;
   assign unused_timeout_param = ^16'(TIMEOUT);
`endif

   // OR-based one-hot to binary encoder; exact because the selector is one-hot.
   function automatic logic [3:0] enc16(input logic [15:0] oh);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (oh[i]) idx = idx | 4'(i);
      end
      return idx;
   endfunction

   // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
   always_comb begin
      req_rot   = 16'({req, req} >> ptr_q);
      first_off = '0;
      for (int i = 15; i >= 0; i--) begin
         if (req_rot[i]) first_off = 4'(i);
      end
      sel_idx = ptr_q + first_off;
      sel_oh  = '0;
      if (|req) sel_oh = 16'(1) << sel_idx;
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
      busy_d      = busy_q;
      ptr_d       = ptr_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
      timeout_d   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               gnt_d       = sel_oh;
               gnt_idx_d   = enc16(sel_oh);
               gnt_valid_d = 1'b1;
               state_d     = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (out_ready) begin
               gnt_valid_d = 1'b0;
               busy_d      = 1'b1;
               ptr_d       = gnt_idx_q + 4'd1;
               state_d     = ST_BUSY;
`ifdef ARB_TIMEOUT_EN
               cnt_d       = '0;
`endif
            end
         end
         ST_BUSY: begin
            if (done) begin
               gnt_d     = '0;
               gnt_idx_d = '0;
               busy_d    = 1'b0;
               state_d   = ST_IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == TimeoutLast) begin
               gnt_d     = '0;
               gnt_idx_d = '0;
               busy_d    = 1'b0;
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         default: begin
            state_d     = ST_IDLE;
            gnt_d       = '0;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         gnt_q       <= '0;
         gnt_idx_q   <= '0;
         gnt_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         ptr_q       <= '0;
`ifdef ARB_TIMEOUT_EN
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         busy_q      <= busy_d;
         ptr_q       <= ptr_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = gnt_valid_q;
   assign busy      = busy_q;
`ifdef ARB_TIMEOUT_EN
   assign timeout   = timeout_q;
`else
   assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Self-checking bench for rr_arbiter_16: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_rr_arbiter_16;

   localparam int unsigned TB_TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] req;
   logic        out_ready;
   logic        done;
   logic [15:0] gnt;
   logic [3:0]  gnt_idx;
   logic        gnt_valid;
   logic        busy;
   logic        timeout;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: phase 0 idle, 1 offered, 2 owned.
   int m_phase = 0;
   int m_ptr   = 0;
   int m_idx   = 0;
   int m_bc    = 0;
   bit m_to    = 1'b0;

   always #5 clk = ~clk;

   rr_arbiter_16 #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .out_ready (out_ready),
      .done      (done),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .busy      (busy),
      .timeout   (timeout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [15:0] r, input int p);
      for (int k = 0; k < 16; k++) begin
         if (r[(p + k) % 16]) return (p + k) % 16;
      end
      return -1;
   endfunction

   task automatic model_edge();
      m_to = 1'b0;
      if (reset) begin
         m_phase = 0;
         m_ptr   = 0;
         m_idx   = 0;
      end else begin
         case (m_phase)
            0: if (req != 16'h0) begin
                  m_idx   = pick(req, m_ptr);
                  m_phase = 1;
               end
            1: if (out_ready) begin
                  m_phase = 2;
                  m_ptr   = (m_idx + 1) % 16;
                  m_bc    = 0;
               end
            default: begin
               m_bc++;
               if (done) m_phase = 0;
`ifdef ARB_TIMEOUT_EN
               else if (m_bc == int'(TB_TIMEOUT)) begin
                  m_phase = 0;
                  m_to    = 1'b1;
               end
`endif
            end
         endcase
      end
   endtask

   task automatic compare_all();
      logic [31:0] exp_gnt;
      exp_gnt = (m_phase != 0) ? (32'd1 << m_idx) : 32'd0;
      check("gnt", 32'(gnt), exp_gnt);
      check("gnt_idx", 32'(gnt_idx), (m_phase != 0) ? 32'(m_idx) : 32'd0);
      check("gnt_valid", 32'(gnt_valid), 32'(m_phase == 1));
      check("busy", 32'(busy), 32'(m_phase == 2));
      check("timeout", 32'(timeout), 32'(m_to));
      check("onehot", 32'($countones(gnt) <= 1), 32'd1);
      check("valid_busy_excl", 32'(gnt_valid & busy), 32'd0);
   endtask

   task automatic step(input logic [15:0] r, input logic o, input logic d, input logic rs);
      req       = r;
      out_ready = o;
      done      = d;
      reset     = rs;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   initial begin
      int bcount;
      bit saw_to;
      logic [15:0] r;

      req = '0; out_ready = 1'b0; done = 1'b0; reset = 1'b1;
      #2;
      step(16'h0, 1'b0, 1'b0, 1'b1);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // Single request handshake.
      step(16'h0001, 1'b0, 1'b0, 1'b0);
      check("single_gnt", 32'(gnt), 32'h0001);
      check("single_valid", 32'(gnt_valid), 32'd1);
      step(16'h0, 1'b1, 1'b0, 1'b0);
      check("single_busy", 32'(busy), 32'd1);
      step(16'h0, 1'b0, 1'b1, 1'b0);
      check("single_release", 32'({gnt, gnt_idx, gnt_valid, busy}), 32'd0);

      // Full rotation with a grant every three cycles.
      step(16'h0, 1'b0, 1'b0, 1'b1);
      for (int t = 0; t < 17; t++) begin
         step(16'hFFFF, 1'b1, 1'b1, 1'b0);
         check("rot_idx", 32'(gnt_idx), 32'(t % 16));
         check("rot_valid", 32'(gnt_valid), 32'd1);
         step(16'hFFFF, 1'b1, 1'b1, 1'b0);
         step(16'hFFFF, 1'b1, 1'b1, 1'b0);
      end

      // Priority wrap: ptr=6 so bit 0 beats bit 4.
      step(16'h0, 1'b0, 1'b0, 1'b1);
      step(16'h0020, 1'b0, 1'b0, 1'b0);
      check("wrap_first_idx", 32'(gnt_idx), 32'd5);
      step(16'h0, 1'b1, 1'b0, 1'b0);
      step(16'h0, 1'b0, 1'b1, 1'b0);
      step(16'h0011, 1'b0, 1'b0, 1'b0);
      check("wrap_gnt", 32'(gnt), 32'h0001);
      check("wrap_idx", 32'(gnt_idx), 32'd0);
      step(16'h0, 1'b1, 1'b0, 1'b0);
      step(16'h0, 1'b0, 1'b1, 1'b0);

      // Grant held while the request drops and the resource stalls.
      step(16'h0, 1'b0, 1'b0, 1'b1);
      step(16'h0008, 1'b0, 1'b0, 1'b0);
      for (int t = 0; t < 10; t++) begin
         step(16'h0, 1'b0, 1'b1, 1'b0);
         check("hold_gnt", 32'(gnt), 32'h0008);
         check("hold_valid", 32'(gnt_valid), 32'd1);
      end
      step(16'h0, 1'b1, 1'b0, 1'b0);
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_busy_gnt", 32'(gnt), 32'h0008);
      step(16'h0, 1'b0, 1'b1, 1'b0);

`ifdef ARB_TIMEOUT_EN
      // Forced release after TB_TIMEOUT busy cycles.
      step(16'h0, 1'b0, 1'b0, 1'b1);
      step(16'h0001, 1'b0, 1'b0, 1'b0);
      step(16'h0, 1'b1, 1'b0, 1'b0);
      bcount = busy ? 1 : 0;
      saw_to = 1'b0;
      for (int t = 0; t < 40 && !saw_to; t++) begin
         step(16'h0, 1'b0, 1'b0, 1'b0);
         if (timeout) saw_to = 1'b1;
         else if (busy) bcount++;
      end
      check("to_seen", 32'(saw_to), 32'd1);
      check("to_busy_cycles", 32'(bcount), 32'(TB_TIMEOUT));
      check("to_idle", 32'({gnt, busy}), 32'd0);
      step(16'h0, 1'b0, 1'b0, 1'b0);
      check("to_pulse_end", 32'(timeout), 32'd0);
`endif

      // Reset while busy, then confirm ptr returned to 0.
      step(16'h0100, 1'b0, 1'b0, 1'b0);
      step(16'h0, 1'b1, 1'b0, 1'b0);
      check("midrst_busy_before", 32'(busy), 32'd1);
      step(16'h0, 1'b0, 1'b0, 1'b1);
      check("midrst_outs", 32'({gnt, gnt_idx, gnt_valid, busy, timeout}), 32'd0);
      step(16'hFFFF, 1'b0, 1'b0, 1'b0);
      check("midrst_idx", 32'(gnt_idx), 32'd0);

      // Random traffic.
      for (int t = 0; t < 3000; t++) begin
         case ($urandom_range(3))
            0: r = 16'h0;
            1: r = 16'(1) << $urandom_range(15);
            2: r = 16'($urandom);
            default: r = 16'hFFFF;
         endcase
         step(r, 1'($urandom_range(1)), ($urandom_range(9) < 3),
              ($urandom_range(199) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
